sram_port0_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the RW port (port 0) of the 32x512 OpenRAM SRAM macro. It shares the single RW port between two masters with a req/gnt/rvalid handshake, fully pipelined at one access per cycle. It returns read data one cycle after grant. When enabled, it first runs a power-up clear sequence that zero-fills the array before any grant. It sits between the core's memory masters and the macro, with the macro's clk0 tied to clk_i.

---
 rtl/sram_port0_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter/sequencer sharing SRAM port 0 between two masters; optional zero-fill via SRAM_INIT_CLEAR_EN.
// Latency: gnt combinational from req, rvalid/rdata one cycle after grant; one access per cycle.
// Backpressure: a master holds req and payload until gnt; no grants while the clear sequence runs.
module sram_port0_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [NUM_WMASKS-1:0] m0_be_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [NUM_WMASKS-1:0] m1_be_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i,
    output logic                  init_done_o
);

    if (DATA_WIDTH != 8 * NUM_WMASKS || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("sram_port0_arbiter: inconsistent DATA_WIDTH/NUM_WMASKS/RAM_DEPTH");
    end

`ifdef SRAM_INIT_CLEAR_EN
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam state_t ST_RESET = ST_CLEAR;
    logic [ADDR_WIDTH-1:0] clr_cnt;
`else
    typedef enum logic {ST_RUN = 1'b1} state_t;
    localparam state_t ST_RESET = ST_RUN;
`endif

    state_t state_q, state_d;
    logic   prio_q;
    logic   rsp_valid_q, rsp_id_q, rsp_we_q;
    logic   gnt0, gnt1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_RESET;
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_we_q    <= 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
            clr_cnt     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            // After a grant, the loser of this cycle gets priority next.
            if (gnt0 || gnt1) prio_q <= gnt0;
            rsp_valid_q <= gnt0 || gnt1;
            rsp_id_q    <= gnt1;
            rsp_we_q    <= gnt1 ? m1_we_i : m0_we_i;
`ifdef SRAM_INIT_CLEAR_EN
            if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
`ifdef SRAM_INIT_CLEAR_EN
        init_done_o   = 1'b0;
`else
        init_done_o   = 1'b1;
`endif
        // Outputs are forced to their idle values while reset is asserted.
        if (rst_ni) begin
            case (state_q)
`ifdef SRAM_INIT_CLEAR_EN
                ST_CLEAR: begin
                    sram_csb0_o   = 1'b0;
                    sram_web0_o   = 1'b0;
                    sram_wmask0_o = '1;
                    sram_addr0_o  = clr_cnt;
                    if (clr_cnt == CLR_LAST) state_d = ST_RUN;
                end
`endif
                ST_RUN: begin
                    init_done_o = 1'b1;
                    if (m0_req_i && m1_req_i) begin
                        gnt0 = !prio_q;
                        gnt1 = prio_q;
                    end else begin
                        gnt0 = m0_req_i;
                        gnt1 = m1_req_i;
                    end
                    if (gnt1) begin
                        sram_csb0_o   = 1'b0;
                        sram_web0_o   = !m1_we_i;
                        sram_wmask0_o = m1_be_i;
                        sram_addr0_o  = m1_addr_i;
                        sram_din0_o   = m1_wdata_i;
                    end else if (gnt0) begin
                        sram_csb0_o   = 1'b0;
                        sram_web0_o   = !m0_we_i;
                        sram_wmask0_o = m0_be_i;
                        sram_addr0_o  = m0_addr_i;
                        sram_din0_o   = m0_wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = rst_ni && rsp_valid_q && !rsp_id_q;
    assign m1_rvalid_o = rst_ni && rsp_valid_q && rsp_id_q;
    assign m0_rdata_o  = (m0_rvalid_o && !rsp_we_q) ? sram_dout0_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && !rsp_we_q) ? sram_dout0_i : '0;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: macro model, reference memory, grant-ordered response scoreboard.
module tb_sram_port0_arbiter;
    localparam int DW = 32, AW = 9, NW = 4, DEPTH = 512;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [1:0] req = '0, we = '0;
    logic [NW-1:0] be[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];

    logic m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic sram_csb0_o, sram_web0_o, init_done_o;
    logic [NW-1:0] sram_wmask0_o;
    logic [AW-1:0] sram_addr0_o;
    logic [DW-1:0] sram_din0_o;
    logic [DW-1:0] dout = '0;

    sram_port0_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_addr_i(addr[0]),
        .m0_wdata_i(wdata[0]), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_addr_i(addr[1]),
        .m1_wdata_i(wdata[1]), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
        .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o), .sram_dout0_i(dout),
        .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] init_word(int i);
        return (DW'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Macro model: latches inputs at posedge, performs the access at the following negedge.
    logic [DW-1:0] mem[DEPTH];
    logic          mem_init = 1'b0;
    logic          l_csb = 1'b1, l_web = 1'b1;
    logic [NW-1:0] l_wm = '0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_din = '0;
    logic [DW-1:0] mword;

    always @(posedge clk_i) begin
        l_csb  <= sram_csb0_o;
        l_web  <= sram_web0_o;
        l_wm   <= sram_wmask0_o;
        l_addr <= sram_addr0_o;
        l_din  <= sram_din0_o;
    end

    always @(negedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (!l_csb) begin
            if (!l_web) begin
                mword = mem[l_addr];
                for (int b = 0; b < NW; b++) if (l_wm[b]) mword[8*b +: 8] = l_din[8*b +: 8];
                mem[l_addr] = mword;
            end else begin
                dout <= mem[l_addr];
            end
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          sb[$];
    int            gnt_hist[$];
    logic [DW-1:0] ref_mem[DEPTH];
    bit            ref_init = 1'b0;
    bit            gflag[2];
    int            tests = 0, fails = 0;
    int            cyc = 0, rel_cyc = 0, clr_writes = 0, last_win = 1;
    bit            seen_done = 1'b0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor/checker: samples after the negedge, pops expected responses in grant order.
    always @(negedge clk_i) begin
        logic [1:0]    exp_rv, exp_g;
        logic [DW-1:0] exp_d0, exp_d1, w_new;
        rsp_t          e;
        int            w;
        #1;
        cyc++;
        gflag[0] = 1'b0;
        gflag[1] = 1'b0;
        if (!ref_init) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst_ni) begin
            check("rst_gnt", {m1_gnt_o, m0_gnt_o}, 2'b00);
            check("rst_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
            check("rst_rdata", {m1_rdata_o, m0_rdata_o}, '0);
            check("rst_bus", {sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o},
                  {1'b1, 1'b1, 45'd0});
`ifdef SRAM_INIT_CLEAR_EN
            check("rst_init_done", init_done_o, 1'b0);
`else
            check("rst_init_done", init_done_o, 1'b1);
`endif
            sb.delete();
            last_win   = 1;
            rel_cyc    = 0;
            clr_writes = 0;
            seen_done  = 1'b0;
        end else begin
            rel_cyc++;
            exp_rv = 2'b00;
            exp_d0 = '0;
            exp_d1 = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_rv[e.id] = 1'b1;
                if (e.id == 0) exp_d0 = e.data;
                else exp_d1 = e.data;
            end
            check("rvalid", {m1_rvalid_o, m0_rvalid_o}, exp_rv);
            check("m0_rdata", m0_rdata_o, exp_d0);
            check("m1_rdata", m1_rdata_o, exp_d1);
`ifndef SRAM_INIT_CLEAR_EN
            check("init_done", init_done_o, 1'b1);
`endif
            if (!init_done_o) begin
                check("clear_gnt", {m1_gnt_o, m0_gnt_o}, 2'b00);
                check("clear_write", {sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o},
                      {1'b0, 1'b0, 4'hF, AW'(clr_writes), 32'd0});
                clr_writes++;
            end else begin
`ifdef SRAM_INIT_CLEAR_EN
                if (!seen_done) begin
                    seen_done = 1'b1;
                    check("init_done_cycle", rel_cyc, DEPTH + 1);
                    check("clear_count", clr_writes, DEPTH);
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end
`endif
                exp_g = 2'b00;
                w = 0;
                if (req != 2'b00) begin
                    if (req == 2'b11) w = (last_win == 0) ? 1 : 0;
                    else w = req[1] ? 1 : 0;
                    exp_g[w] = 1'b1;
                end
                check("gnt", {m1_gnt_o, m0_gnt_o}, exp_g);
                if (exp_g != 2'b00) begin
                    check("bus_access", {sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o},
                          {1'b0, !we[w], be[w], addr[w], wdata[w]});
                    e.id  = w;
                    e.due = cyc + 1;
                    if (we[w]) begin
                        w_new = ref_mem[addr[w]];
                        for (int b = 0; b < NW; b++) if (be[w][b]) w_new[8*b +: 8] = wdata[w][8*b +: 8];
                        ref_mem[addr[w]] = w_new;
                        e.data = '0;
                    end else begin
                        e.data = ref_mem[addr[w]];
                    end
                    sb.push_back(e);
                    last_win = w;
                    gflag[w] = 1'b1;
                    gnt_hist.push_back(w);
                end else begin
                    check("bus_idle", {sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o},
                          {1'b1, 1'b1, 45'd0});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(int m, logic w, logic [NW-1:0] b, logic [AW-1:0] a, logic [DW-1:0] d);
        req[m] = 1'b1; we[m] = w; be[m] = b; addr[m] = a; wdata[m] = d;
    endtask

    task automatic idle(int m);
        req[m] = 1'b0; we[m] = 1'b0; be[m] = '0; addr[m] = '0; wdata[m] = '0;
    endtask

    task automatic issue(int m, logic w, logic [NW-1:0] b, logic [AW-1:0] a, logic [DW-1:0] d);
        set_req(m, w, b, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            #2;
            if (gflag[m]) begin
                tick();
                idle(m);
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL issue_timeout: master %0d got no gnt within 20 cycles", m);
        tick();
        idle(m);
    endtask

    task automatic wait_init();
        for (int k = 0; k < DEPTH + 20; k++) begin
            if (init_done_o) return;
            tick();
        end
        tests++;
        fails++;
        $display("FAIL init_timeout: init_done_o %0b required 1", init_done_o);
    endtask

    task automatic do_reset(int n);
        rst_ni = 1'b0;
        repeat (n) tick();
        rst_ni = 1'b1;
    endtask

    int exp_seq[4] = '{0, 1, 0, 1};

    initial begin
        idle(0);
        idle(1);
        set_req(0, 1'b0, '0, 9'h000, '0);
        repeat (3) tick();
        idle(0);
        rst_ni = 1'b1;
        wait_init();
`ifdef SRAM_INIT_CLEAR_EN
        issue(0, 1'b0, 4'hF, 9'h1FF, '0);
`endif
        issue(0, 1'b1, 4'hF, 9'd5, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'hF, 9'd5, '0);
        issue(1, 1'b1, 4'hF, 9'd7, 32'h0);
        issue(1, 1'b1, 4'b0101, 9'd7, 32'h1122_3344);
        issue(1, 1'b0, 4'hF, 9'd7, '0);
        issue(0, 1'b1, 4'b0000, 9'd5, 32'hFFFF_FFFF);
        issue(0, 1'b0, 4'hF, 9'd5, '0);
        repeat (2) tick();

        do_reset(2);
        wait_init();
        gnt_hist.delete();
        set_req(0, 1'b0, 4'hF, 9'd1, '0);
        set_req(1, 1'b0, 4'hF, 9'd2, '0);
        repeat (4) tick();
        idle(0);
        idle(1);
        check("contention_len", gnt_hist.size(), 4);
        for (int i = 0; i < 4 && i < gnt_hist.size(); i++) check("contention_order", gnt_hist[i], exp_seq[i]);
        repeat (2) tick();

        issue(0, 1'b0, 4'hF, 9'd3, '0);
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        wait_init();
        gnt_hist.delete();
        set_req(0, 1'b0, 4'hF, 9'd4, '0);
        set_req(1, 1'b0, 4'hF, 9'd6, '0);
        tick();
        idle(0);
        idle(1);
        check("prio_after_reset", gnt_hist.size() > 0 ? gnt_hist[0] : -1, 0);
        repeat (2) tick();

        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!req[m] || gflag[m]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(m, 1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom_range(0, 15)), $urandom);
                    else
                        idle(m);
                end
            end
            tick();
        end
        idle(0);
        idle(1);
        repeat (3) tick();
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
